// File: rtl/fir_mac_secuenciador_pkg.sv
// Shared Q-format constants, saturation limits, accumulator sizing and FSM encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fir_mac_secuenciador_pkg;

    // Default Q-format: 1 sign bit, Q_P integer bits, Q_F fraction bits.
    localparam int Q_N    = 12;
    localparam int Q_P    = 4;
    localparam int Q_F    = Q_N - Q_P - 1;
    localparam int Q_TAPS = 8;
    localparam int Q_G    = 3;

    // Fraction bits of an n-bit word with p integer bits.
    function automatic int frac_bits(input int n, input int p);
        return n - p - 1;
    endfunction

    // Accumulator width: full 2n-bit product plus g guard bits for the tap sum.
    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

    // Largest positive n-bit two's-complement word: 0 followed by all ones.
    function automatic logic [31:0] max_pos(input int n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    // Most negative n-bit two's-complement word: 1 followed by all zeros.
    function automatic logic [31:0] max_neg(input int n);
        return 32'd1 << (n - 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        SAT   = 2'd3
    } state_t;

endpackage

// File: rtl/fir_mac_secuenciador_trunc_sat.sv
// Saturating truncation of the accumulator (fraction LSBs already dropped) to an N-bit word.
// Latency: combinational.
// Backpressure: none; output follows input.
module fir_mac_secuenciador_trunc_sat
    import fir_mac_secuenciador_pkg::*;
#(
    parameter int N = Q_N,
    parameter int P = Q_P,
    parameter int G = Q_G
) (
    input  logic [acc_width(N, G)-frac_bits(N, P)-1:0] acc_hi,
    output logic [N-1:0]                               y,
    output logic                                       ovf
);

    localparam int F  = frac_bits(N, P);
    localparam int HW = acc_width(N, G) - F;

    // acc_hi holds acc[2N+G-1:F]; its low N bits are the floored candidate and
    // everything from bit N-1 upward must be a pure sign extension to fit.
    logic          sign;
    logic [HW-N:0] top;
    logic          fits;

    // Range check on the integer/sign part, then pick candidate or clamp by sign.
    always_comb begin
        sign = acc_hi[HW-1];
        top  = acc_hi[HW-1:N-1];
        fits = (&top) | ~(|top);
        if (fits) begin
            y   = acc_hi[N-1:0];
            ovf = 1'b0;
        end else begin
            y   = sign ? N'(max_neg(N)) : N'(max_pos(N));
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_secuenciador.sv
// One FIR output per accepted sample using a single shared MAC over TAPS taps.
// Latency: y_valid in the cycle after edge E0+TAPS+2 (E0 = accepting edge).
// Backpressure: start while busy is dropped, never queued.
module fir_mac_secuenciador
    import fir_mac_secuenciador_pkg::*;
#(
    parameter int N    = Q_N,
    parameter int P    = Q_P,
    parameter int TAPS = Q_TAPS,
    parameter int G    = Q_G
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N-1:0]            x_in,
    output logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [N-1:0]            coef_in,
    output logic [N-1:0]            y_out,
    output logic                    y_valid,
    output logic                    overflow,
    output logic                    busy
);

    localparam int KW = $clog2(TAPS);
    localparam int AW = acc_width(N, G);
    localparam int F  = frac_bits(N, P);

    state_t          state;
    logic [N-1:0]    dline [TAPS];
    logic [KW-1:0]   k;
    logic [AW-1:0]   acc;
    logic [2*N-1:0]  xs;
    logic [2*N-1:0]  cs;
    logic [2*N-1:0]  prod;
    logic [AW-1:0]   prod_ext;
    logic [N-1:0]    sat_y;
    logic            sat_ovf;

    // Both operands sign-extended to 2N bits, so the low 2N bits of the
    // product are the exact signed product.
    assign xs       = {{N{dline[k][N-1]}}, dline[k]};
    assign cs       = {{N{coef_in[N-1]}}, coef_in};
    assign prod     = xs * cs;
    assign prod_ext = {{(AW-2*N){prod[2*N-1]}}, prod};

    fir_mac_secuenciador_trunc_sat #(
        .N (N),
        .P (P),
        .G (G)
    ) u_trunc_sat (
        .acc_hi (acc[AW-1:F]),
        .y      (sat_y),
        .ovf    (sat_ovf)
    );

    // Sequencer: delay line, ROM addressing, accumulation and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            coef_addr <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dline[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            dline[i] <= dline[i-1];
                        end
                        acc       <= '0;
                        coef_addr <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // Address 0 is being read this cycle; queue address 1.
                    coef_addr <= KW'(1);
                    k         <= '0;
                    state     <= MAC;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + 1'b1;
                    // ROM runs one address ahead of k; park on the last tap.
                    if (int'(k) + 2 < TAPS) begin
                        coef_addr <= coef_addr + 1'b1;
                    end
                    if (k == KW'(TAPS - 1)) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    y_out    <= sat_y;
                    overflow <= sat_ovf;
                    y_valid  <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_secuenciador.sv
// Self-checking bench: arithmetic FIR model plus directed literal vectors.
// Latency: checks y_valid exactly TAPS+2 edges after each accepted start.
// Backpressure: exercises start-while-busy and start coincident with y_valid.
module tb_fir_mac_secuenciador;

    localparam int TAPS = 8;
    localparam int LAT  = TAPS + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] x_in;
    logic [2:0]  coef_addr;
    logic [11:0] coef_in;
    logic [11:0] y_out;
    logic        y_valid;
    logic        overflow;
    logic        busy;

    fir_mac_secuenciador dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .coef_addr (coef_addr),
        .coef_in   (coef_in),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous coefficient ROM, one cycle of latency.
    logic [11:0] rom [TAPS];
    always @(posedge clk) coef_in <= rom[coef_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int n_vld = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int y;
        int ovf;
    } res_t;

    res_t        pend [$];
    int          hist [TAPS];
    int          ec = 0;
    int          last_a = -1;
    logic        exp_vld = 1'b0;
    logic        exp_busy = 1'b0;
    logic [11:0] exp_y = '0;
    logic        exp_ovf = 1'b0;
    bit          run_cmp = 1'b0;

    always @(posedge reset) begin
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        pend.delete();
        last_a   = -1;
        exp_vld  = 1'b0;
        exp_busy = 1'b0;
        exp_y    = '0;
        exp_ovf  = 1'b0;
    end

    always @(posedge clk) begin
        int     e;
        longint sum;
        longint yv;
        int     ov;
        e = ec;
        ec++;
        if (!reset) begin
            // The datapath is free again once a full TAPS+3 edges have passed.
            if (start && (last_a < 0 || e - last_a >= LAT + 1)) begin
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'($signed(x_in));
                sum = 0;
                for (int t = 0; t < TAPS; t++) sum += longint'(hist[t]) * longint'($signed(rom[t]));
                yv = sum >>> 7;
                ov = 0;
                if (yv > 2047) begin
                    yv = 2047;
                    ov = 1;
                end else if (yv < -2048) begin
                    yv = -2048;
                    ov = 1;
                end
                pend.push_back('{e + LAT, int'(yv), ov});
                last_a = e;
            end
            exp_vld = 1'b0;
            if (pend.size() > 0 && pend[0].due == e) begin
                exp_vld = 1'b1;
                exp_y   = 12'(pend[0].y);
                exp_ovf = pend[0].ovf[0];
                void'(pend.pop_front());
            end
            exp_busy = (last_a >= 0) && (e - last_a <= LAT - 1);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("y_valid", y_valid, exp_vld);
            check("busy", busy, exp_busy);
            check("y_out", y_out, exp_y);
            check("overflow", overflow, exp_ovf);
        end
        if (y_valid) n_vld++;
    end

    // ---------------- directed stimulus ----------------
    task automatic set_rom(input logic [11:0] c0, input logic [11:0] rest);
        rom[0] = c0;
        for (int i = 1; i < TAPS; i++) rom[i] = rest;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic send(input string name, input logic [11:0] x, input logic [11:0] ey, input logic eo);
        int lat;
        logic [11:0] gy;
        logic go;
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        gy  = 'x;
        go  = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) begin
                lat = i;
                gy  = y_out;
                go  = overflow;
                break;
            end
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_y"}, gy, ey);
        check({name, "_ovf"}, go, eo);
    endtask

    initial begin
        int seen;
        int v0;
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        set_rom(12'h080, 12'h080);
        #1;
        check("rst_y_out", y_out, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_coef_addr", coef_addr, 0);
        run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        // Impulse through unit coefficients.
        send("imp0", 12'h080, 12'h080, 1'b0);
        for (int i = 1; i < 8; i++) send("imp", 12'h000, 12'h080, 1'b0);
        send("imp8", 12'h000, 12'h000, 1'b0);
        send("imp9", 12'h000, 12'h000, 1'b0);

        // Sign, scale and floor direction with a single half-weight tap.
        set_rom(12'h040, 12'h000);
        send("scale_neg", 12'hF80, 12'hFC0, 1'b0);
        send("trunc_pos", 12'h001, 12'h000, 1'b0);
        send("trunc_neg", 12'hFFF, 12'hFFF, 1'b0);

        // Positive then negative saturation.
        set_rom(12'h080, 12'h080);
        do_reset();
        send("satp1", 12'h7FF, 12'h7FF, 1'b0);
        for (int i = 1; i < 8; i++) send("satp", 12'h7FF, 12'h7FF, 1'b1);
        do_reset();
        send("satn1", 12'h800, 12'h800, 1'b0);
        for (int i = 1; i < 8; i++) send("satn", 12'h800, 12'h800, 1'b1);

        // Start while busy is ignored; start alongside y_valid is accepted.
        do_reset();
        v0 = n_vld;
        @(negedge clk);
        start = 1'b1;
        x_in  = 12'h100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        x_in  = 12'h300;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) seen = 1;
        end
        check("busy_first_seen", seen, 1);
        check("busy_first_y", y_out, 12'h100);
        start = 1'b1;
        x_in  = 12'h010;
        @(posedge clk);
        #1 start = 1'b0;
        check("coincident_busy", busy, 1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) seen = 1;
        end
        check("coincident_seen", seen, 1);
        check("coincident_y", y_out, 12'h110);
        repeat (3) @(posedge clk);
        check("busy_vld_count", n_vld - v0, 2);

        // Reset during the fifth MAC cycle, then a clean impulse.
        do_reset();
        send("pre1", 12'h100, 12'h100, 1'b0);
        send("pre2", 12'h100, 12'h200, 1'b0);
        @(negedge clk);
        start = 1'b1;
        x_in  = 12'h080;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_y_out", y_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_y_valid", y_valid, 0);
        check("midrst_coef_addr", coef_addr, 0);
        v0 = n_vld;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_vld", n_vld - v0, 0);
        send("post0", 12'h080, 12'h080, 1'b0);
        for (int i = 1; i < 8; i++) send("post", 12'h000, 12'h080, 1'b0);
        send("post8", 12'h000, 12'h000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("model_drained", pend.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
